// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin CPU/DMA arbiter onto a single memory port.
// Optional wait-state timeout with bus error is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_write,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              bus_err
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state;
    logic last_dma;
    logic sel_dma;
    logic win_dma;
    logic done;
    logic [DATA_W-1:0] rd_val;
    if (TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("mem_arbiter: TIMEOUT_CYC must be at least 1");
    end
    // On a tie the requester that was not served last wins
    assign win_dma = dma_req && (!cpu_req || !last_dma);
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic timeout;
    assign timeout = !mem_ready && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign done    = mem_ready || timeout;
    assign rd_val  = mem_ready ? mem_rdata : '1;
`else
    assign done    = mem_ready;
    assign rd_val  = mem_rdata;
    assign bus_err = 1'b0;
`endif
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            last_dma  <= 1'b1;
            sel_dma   <= 1'b0;
            cpu_gnt   <= 1'b0;
            dma_gnt   <= 1'b0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            mem_en    <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            bus_err   <= 1'b0;
            wait_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        state     <= ACCESS;
                        sel_dma   <= win_dma;
                        last_dma  <= win_dma;
                        cpu_gnt   <= !win_dma;
                        dma_gnt   <= win_dma;
                        mem_en    <= 1'b1;
                        mem_write <= win_dma ? dma_write : cpu_write;
                        mem_addr  <= win_dma ? dma_addr : cpu_addr;
                        mem_wdata <= win_dma ? dma_wdata : cpu_wdata;
`ifdef MEM_ARB_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end
                end
                ACCESS: begin
                    if (done) begin
                        state     <= RESP;
                        mem_en    <= 1'b0;
                        mem_write <= 1'b0;
                        cpu_ack   <= !sel_dma;
                        dma_ack   <= sel_dma;
                        if (!mem_write && !sel_dma) cpu_rdata <= rd_val;
                        if (!mem_write && sel_dma) dma_rdata <= rd_val;
`ifdef MEM_ARB_TIMEOUT_EN
                        bus_err   <= !mem_ready;
                    end else begin
                        wait_cnt  <= wait_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    cpu_gnt <= 1'b0;
                    dma_gnt <= 1'b0;
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                    bus_err <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transaction checks of mem_arbiter
// against a transaction-level reference of arbitration order and read data.
module tb_mem_arbiter;
    logic       Clk = 1'b0;
    logic       Reset;
    logic       cpu_req, cpu_write, cpu_gnt, cpu_ack;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       dma_req, dma_write, dma_gnt, dma_ack;
    logic [7:0] dma_addr, dma_wdata, dma_rdata;
    logic       mem_en, mem_write, mem_ready, bus_err;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_cpu_rd, exp_dma_rd;
    bit         last_dma;
    logic [1:0] got_q[$];
    logic [1:0] exp_q[$];

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYC(16)) dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_write(dma_write), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_err(bus_err)
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sole requester wins; on a tie, whoever was not served last wins
    function automatic bit pick_dma(input bit c, input bit d);
        if (c && d) return !last_dma;
        return d;
    endfunction

    task automatic check_rdata(input string tag);
        chk_d({tag, "_cpu_rdata"}, cpu_rdata, exp_cpu_rd);
        chk_d({tag, "_dma_rdata"}, dma_rdata, exp_dma_rd);
    endtask

    // One complete access starting from IDLE; requests drop right after grant
    task automatic run_txn(input bit c, input bit d, input bit cwr, input bit dwr,
                           input logic [7:0] ca, input logic [7:0] cw,
                           input logic [7:0] da, input logic [7:0] dw,
                           input logic [7:0] rv, input int waits);
        bit wd, wr;
        logic [7:0] a, wv;
        wd = pick_dma(c, d);
        wr = wd ? dwr : cwr;
        a  = wd ? da : ca;
        wv = wd ? dw : cw;
        cpu_req = c; cpu_write = cwr; cpu_addr = ca; cpu_wdata = cw;
        dma_req = d; dma_write = dwr; dma_addr = da; dma_wdata = dw;
        mem_ready = 1'b0; mem_rdata = ~rv;
        tick;
        last_dma = wd;
        chk_b("acc_cpu_gnt", cpu_gnt, !wd);
        chk_b("acc_dma_gnt", dma_gnt, wd);
        chk_b("acc_mem_en", mem_en, 1'b1);
        chk_b("acc_mem_write", mem_write, wr);
        chk_d("acc_mem_addr", mem_addr, a);
        chk_d("acc_mem_wdata", mem_wdata, wv);
        chk_b("acc_no_ack", cpu_ack | dma_ack, 1'b0);
        cpu_req = 1'b0; dma_req = 1'b0;
        cpu_addr = ~ca; dma_addr = ~da; cpu_wdata = ~cw; dma_wdata = ~dw;
        cpu_write = !cwr; dma_write = !dwr;
        for (int i = 0; i < waits; i++) begin
            tick;
            chk_b("wait_mem_en", mem_en, 1'b1);
            chk_d("wait_mem_addr", mem_addr, a);
            chk_b("wait_mem_write", mem_write, wr);
            chk_b("wait_no_ack", cpu_ack | dma_ack, 1'b0);
        end
        mem_ready = 1'b1; mem_rdata = rv;
        tick;
        if (!wr && wd) exp_dma_rd = rv;
        if (!wr && !wd) exp_cpu_rd = rv;
        chk_b("resp_cpu_ack", cpu_ack, !wd);
        chk_b("resp_dma_ack", dma_ack, wd);
        chk_b("resp_gnt_held", wd ? dma_gnt : cpu_gnt, 1'b1);
        chk_b("resp_one_gnt", cpu_gnt & dma_gnt, 1'b0);
        chk_b("resp_mem_en", mem_en, 1'b0);
        chk_b("resp_mem_write", mem_write, 1'b0);
        chk_b("resp_bus_err", bus_err, 1'b0);
        check_rdata("resp");
        mem_ready = 1'b0; mem_rdata = 8'h00;
        tick;
        chk_b("idle_ack", cpu_ack | dma_ack, 1'b0);
        chk_b("idle_gnt", cpu_gnt | dma_gnt, 1'b0);
        chk_b("idle_mem_en", mem_en, 1'b0);
        chk_d("idle_addr_held", mem_addr, a);
        chk_d("idle_wdata_held", mem_wdata, wv);
    endtask

    initial begin
        Reset = 1'b1;
        cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 8'h5E; cpu_wdata = 8'h9C;
        dma_req = 1'b1; dma_write = 1'b0; dma_addr = 8'h71; dma_wdata = 8'h2B;
        mem_ready = 1'b1; mem_rdata = 8'hEE;
        tick;
        tick;
        exp_cpu_rd = 8'h00; exp_dma_rd = 8'h00; last_dma = 1'b1;
        chk_b("rst_cpu_gnt", cpu_gnt, 1'b0);
        chk_b("rst_dma_gnt", dma_gnt, 1'b0);
        chk_b("rst_ack", cpu_ack | dma_ack, 1'b0);
        chk_b("rst_mem_en", mem_en, 1'b0);
        chk_b("rst_mem_write", mem_write, 1'b0);
        chk_b("rst_bus_err", bus_err, 1'b0);
        chk_d("rst_mem_addr", mem_addr, 8'h00);
        chk_d("rst_mem_wdata", mem_wdata, 8'h00);
        check_rdata("rst");

        // Both requesters held high straight after reset
        Reset = 1'b0;
        cpu_write = 1'b1; dma_write = 1'b1; cpu_addr = 8'h01; dma_addr = 8'h02;
        for (int i = 0; i < 3; i++) begin
            bit w;
            w = pick_dma(1'b1, 1'b1);
            exp_q.push_back(w ? 2'b01 : 2'b10);
            last_dma = w;
        end
        for (int i = 0; i < 9; i++) begin
            tick;
            chk_b("tie_one_gnt", cpu_gnt & dma_gnt, 1'b0);
            if (mem_en) got_q.push_back({cpu_gnt, dma_gnt});
            if (i == 8) begin cpu_req = 1'b0; dma_req = 1'b0; mem_ready = 1'b0; end
        end
        chk_d("tie_grant_count", 8'(got_q.size()), 8'd3);
        for (int i = 0; i < 3; i++)
            chk_d("tie_order", 8'(i < got_q.size() ? got_q[i] : 2'bxx), 8'(exp_q[i]));
        check_rdata("tie");

        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 8'h00, 8'hA5, 0);
        run_txn(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h3C, 8'h5A, 8'hC3, 3);
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 8'h00, 8'h00, 8'h6B, 15);

        for (int n = 0; n < 40; n++) begin
            bit c, d;
            c = 1'($urandom); d = 1'($urandom);
            if (!c && !d) c = 1'b1;
            run_txn(c, d, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

        // Memory never ready
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 8'h22; dma_req = 1'b0;
        mem_ready = 1'b0; mem_rdata = 8'h33;
        tick;
        last_dma = 1'b0;
        chk_b("to_enter", mem_en, 1'b1);
        cpu_req = 1'b0;
        for (int i = 2; i <= 16; i++) begin
            tick;
            chk_b("to_wait_ack", cpu_ack, 1'b0);
            chk_b("to_wait_en", mem_en, 1'b1);
        end
        tick;
`ifdef MEM_ARB_TIMEOUT_EN
        exp_cpu_rd = 8'hFF;
        chk_b("to_ack", cpu_ack, 1'b1);
        chk_b("to_bus_err", bus_err, 1'b1);
        chk_b("to_mem_en", mem_en, 1'b0);
        check_rdata("to");
        tick;
        chk_b("to_err_clear", bus_err, 1'b0);
        chk_b("to_ack_clear", cpu_ack, 1'b0);
`else
        chk_b("nto_no_ack", cpu_ack, 1'b0);
        chk_b("nto_still_access", mem_en, 1'b1);
        chk_b("nto_bus_err", bus_err, 1'b0);
        mem_ready = 1'b1;
        tick;
        exp_cpu_rd = 8'h33;
        chk_b("nto_late_ack", cpu_ack, 1'b1);
        check_rdata("nto");
        mem_ready = 1'b0;
        tick;
`endif

        // Reset during ACCESS, with request and ready both active
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 8'h44; dma_req = 1'b0;
        mem_ready = 1'b0;
        tick;
        chk_b("rma_access", mem_en, 1'b1);
        Reset = 1'b1; mem_ready = 1'b1; mem_rdata = 8'h77;
        tick;
        exp_cpu_rd = 8'h00; exp_dma_rd = 8'h00; last_dma = 1'b1;
        chk_b("rma_gnt", cpu_gnt | dma_gnt, 1'b0);
        chk_b("rma_ack", cpu_ack | dma_ack, 1'b0);
        chk_b("rma_mem_en", mem_en, 1'b0);
        chk_d("rma_mem_addr", mem_addr, 8'h00);
        check_rdata("rma");
        Reset = 1'b0; cpu_req = 1'b0; mem_ready = 1'b0;
        tick;
        chk_b("rma_idle_ack", cpu_ack | dma_ack, 1'b0);
        chk_b("rma_idle_en", mem_en, 1'b0);
        run_txn(1'b1, 1'b1, 1'b0, 1'b0, 8'h81, 8'h00, 8'h82, 8'h00, 8'h99, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have these parameters: ADDR_W, default 8, address width; DATA_W, default 8, data width; TIMEOUT_CYC, default 16, wait-state limit.
REQ-002 The block SHALL have these ports (clock and reset first): Clk in 1, sole clock, rising edge; Reset in 1, synchronous active-high reset.
REQ-003 CPU requester ports SHALL be: cpu_req in 1; cpu_write in 1; cpu_addr in ADDR_W; cpu_wdata in DATA_W; cpu_gnt out 1; cpu_ack out 1; cpu_rdata out DATA_W.
REQ-004 DMA requester ports SHALL be: dma_req in 1; dma_write in 1; dma_addr in ADDR_W; dma_wdata in DATA_W; dma_gnt out 1; dma_ack out 1; dma_rdata out DATA_W.
REQ-005 Memory ports SHALL be: mem_en out 1; mem_write out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_rdata in DATA_W; mem_ready in 1.
REQ-006 The error port SHALL be bus_err out 1, pulsed with ack on an aborted access.

Function
REQ-007 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-008 In IDLE with any req high, the block SHALL latch the winner's write, addr and wdata, and go to ACCESS on the next edge.
REQ-009 Arbitration SHALL be round-robin: a sole requester wins; on a tie, the requester not served last wins; the last-winner pointer updates on entry to ACCESS.
REQ-010 In ACCESS, mem_en SHALL be 1, mem_addr, mem_wdata and mem_write SHALL be driven from the latched values, and the winner's gnt SHALL be 1.
REQ-011 ACCESS SHALL hold until mem_ready=1; on that cycle the block SHALL register mem_rdata into the winner's rdata (reads only) and go to RESP.
REQ-012 In RESP, the winner's ack SHALL be 1 for exactly one cycle, gnt SHALL stay 1, and the next state SHALL be IDLE.
REQ-013 Minimum latency SHALL be: req sampled at edge k, mem_en high in cycle k+1, ack high in cycle k+2 (with mem_ready=1 in the first ACCESS cycle).
REQ-014 The rdata outputs SHALL hold their value until that requester's next completed read.
REQ-015 Writes SHALL leave rdata unchanged.
REQ-016 A requester SHALL be granted at most one access per IDLE pass, so back-to-back requests from both requesters alternate.
REQ-017 A req still high in the IDLE cycle after ack SHALL be treated as a new request.
REQ-018 If req drops during ACCESS, the access SHALL still complete and be acked.
REQ-019 Address and data changes after grant SHALL be ignored, because the values are latched.
REQ-020 When not in ACCESS, mem_en and mem_write SHALL be 0, and mem_addr and mem_wdata SHALL hold their last values.
REQ-021 At most one gnt SHALL be high in any cycle, and each gnt SHALL be high only in ACCESS or RESP.

Reset
REQ-022 Reset=1 at a rising edge SHALL force: state IDLE; gnt, ack, mem_en, mem_write and bus_err all 0; mem_addr, mem_wdata and both rdata 0; last-winner pointer = DMA, so CPU wins the first tie.
REQ-023 Reset asserted mid-ACCESS or mid-RESP SHALL abort the access without an ack.
REQ-024 Reset SHALL have priority over all other inputs.

Configuration
REQ-025 The wait-state timeout feature SHALL be controlled by the macro MEM_ARB_TIMEOUT_EN.
REQ-026 With MEM_ARB_TIMEOUT_EN defined: a counter SHALL clear on entry to ACCESS and count cycles with mem_ready=0; when it reaches TIMEOUT_CYC, the access SHALL be aborted and the block SHALL go to RESP with ack=1, bus_err=1, and the winner's rdata set to all ones on a read.
REQ-027 With MEM_ARB_TIMEOUT_EN defined, mem_ready=1 on the same cycle the count reaches the limit SHALL win, with a normal completion and bus_err=0.
REQ-028 Without MEM_ARB_TIMEOUT_EN: ACCESS SHALL wait indefinitely, bus_err SHALL be tied to 0, and no counter SHALL exist.

Verification
REQ-029 CPU read: cpu_req=1, addr 0x10, mem_rdata 0xA5, mem_ready=1 -> mem_en high at k+1, cpu_ack at k+2, cpu_rdata=0xA5.
REQ-030 Tie after reset: cpu_req and dma_req high together and held -> grants go CPU, DMA, CPU, and dma_gnt is never high while cpu_gnt is high.
REQ-031 DMA write: addr 0x3C, wdata 0x5A, mem_ready low for 3 cycles -> mem_write=1 and mem_en=1 for 4 cycles, then dma_ack; dma_rdata unchanged.
REQ-032 Reset mid-access: Reset=1 during ACCESS -> next cycle IDLE, all outputs 0, no ack.
REQ-033 Timeout (macro defined, TIMEOUT_CYC=16): mem_ready held 0 -> ack and bus_err after 16 ACCESS cycles, cpu_rdata=0xFF; without the macro -> no ack, still in ACCESS.
